cla_word_sequencer: RTL
=======================

// Module: cla_word_sequencer
// PURPOSE
//  Shares one external 16-bit carry-lookahead adder between two requesters and
//  sequences multi-word (up to 64-bit) additions through it, one 16-bit word per cycle.
//  Each word's carry-out is fed to the next word's carry-in.
//  Sits between the multiplier's partial-product accumulators and the single shared
//  CLA instance.
// PARAMETERS
//  WORD_W     16  width of one adder word; must match the attached adder
//  MAX_WORDS  4   maximum words per operation; operands are WORD_W*MAX_WORDS bits
//  NW_W       3   width of nwords fields; must hold MAX_WORDS
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 synchronous, active-high reset
//  req0_valid   in   1                 requester 0 has an operation
//  req0_ready   out  1                 requester 0 operation accepted this cycle
//  req0_a       in   WORD_W*MAX_WORDS  operand A, word 0 = LSBs
//  req0_b       in   WORD_W*MAX_WORDS  operand B
//  req0_cin     in   1                 carry into word 0
//  req0_nwords  in   NW_W              words to add; 0 or >MAX_WORDS means MAX_WORDS
//  req1_*       same set as req0_*, for requester 1
//  add_a        out  WORD_W            to shared adder A
//  add_b        out  WORD_W            to shared adder B
//  add_cin      out  1                 to shared adder Cin
//  add_sum      in   WORD_W            from shared adder Sum; combinational, same cycle
//  add_cout     in   1                 from shared adder Cout
//  res_valid    out  1                 result available
//  res_ready    in   1                 consumer takes result
//  res_sum      out  WORD_W*MAX_WORDS  sum; words >= nwords are zero
//  res_cout     out  1                 carry out of the last processed word
//  res_id       out  1                 requester that owns the result
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, all internal registers 0, last_grant=1.
//   last_grant=1 means req0 wins the first tie.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - Grant is combinational and round-robin.
//   - If only one requester is valid, that requester is granted.
//   - If both are valid, grant goes to the requester other than last_grant.
//   - reqN_ready=1 only for the granted requester, only in IDLE.
//   - On valid&ready: latch A, B, cin and clamped n; set last_grant and res_id.
//     Clear the sum register and word index k=0. Go to RUN.
//  RUN (n cycles):
//   - Drive add_a=A[k], add_b=B[k], add_cin=carry (carry = latched cin when k=0).
//   - Each cycle: sum word k <= add_sum; carry <= add_cout; k++.
//   - After word n-1: res_cout <= add_cout; go to DONE.
//  DONE:
//   - res_valid=1; res_sum, res_cout and res_id are held stable while stalled.
//   - On res_ready go to IDLE next cycle; res_valid drops there.
//   - No new request is accepted in DONE.
//  add_a, add_b and add_cin are 0 outside RUN.
//  Latency: accept at cycle T, res_valid at T+n+1.
//   Minimum accept-to-accept spacing is n+2 cycles.
//  Requests arriving during RUN or DONE wait; valid must be held until ready.
//  Carry never wraps into word 0. Overflow beyond word n-1 appears only on res_cout.
//  rst in any state aborts the operation immediately: no result, state returns to IDLE.
// TESTING
//  1. req0: a=0x0000_0000_0001_FFFF, b=1, cin=0, n=2 -> res_sum=0x2_0000, res_cout=0,
//     res_id=0, res_valid at accept+3.
//  2. req1: a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1, n=4 -> res_sum=0xFFFF_FFFF_FFFF_FFFF,
//     res_cout=1, res_id=1.
//  3. Both valid from reset, held -> req0 served first, then req1, then req0
//     (strict alternation).
//  4. req0 a=0x1234_0005, b=0x1111_0003, n=1 -> res_sum=0x0000_0008;
//     n=0 with a=0xFFFF, b=1 -> 4 words, res_sum=0x1_0000.
//  5. res_ready low for 5 cycles in DONE -> res_valid and res_sum stable, req1 stays unready.
//  6. rst during RUN word 2 -> next cycle IDLE, all outputs 0, no res_valid.
//     A fresh request then completes correctly.

Source files
------------

// File: rtl/cla_word_sequencer_if.sv
// Bundle between two requesters, the shared 16-bit CLA and the result consumer.
// slave: the sequencer side; master: requesters, adder and consumer side.
interface cla_word_sequencer_if #(
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 4,
  parameter int NW_W      = 3
);
  localparam int OW = WORD_W * MAX_WORDS;

  logic            req0_valid;
  logic            req0_ready;
  logic [OW-1:0]   req0_a;
  logic [OW-1:0]   req0_b;
  logic            req0_cin;
  logic [NW_W-1:0] req0_nwords;

  logic            req1_valid;
  logic            req1_ready;
  logic [OW-1:0]   req1_a;
  logic [OW-1:0]   req1_b;
  logic            req1_cin;
  logic [NW_W-1:0] req1_nwords;

  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_sum;
  logic          res_cout;
  logic          res_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_nwords,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_nwords,
    output req1_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output res_valid, res_sum, res_cout, res_id,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_nwords,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin, req1_nwords,
    input  req1_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  res_valid, res_sum, res_cout, res_id,
    output res_ready
  );
endinterface

// File: rtl/cla_word_sequencer.sv
// Round-robin shares one WORD_W CLA between two requesters, one word per cycle.
// Ports: clk, rst (sync, active-high), bus (slave modport of the bundle).
module cla_word_sequencer #(
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 4,
  parameter int NW_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  cla_word_sequencer_if.slave bus
);
  localparam int KW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [NW_W-1:0] NMAX = NW_W'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic [MAX_WORDS-1:0][WORD_W-1:0] a_q;
  logic [MAX_WORDS-1:0][WORD_W-1:0] b_q;
  logic [MAX_WORDS-1:0][WORD_W-1:0] sum_q;
  logic            carry;
  logic            last_grant;
  logic            cout_q;
  logic            id_q;
  logic            valid_q;
  logic [NW_W-1:0] n_q;
  logic [NW_W-1:0] k;

  logic            gnt;
  logic            idle;
  logic            take;
  logic            run;
  logic [KW-1:0]   ki;
  logic [NW_W-1:0] nw_sel;
  logic [NW_W-1:0] n_clamp;

  assign ki   = k[KW-1:0];
  assign run  = (state == RUN);
  assign idle = (state == IDLE) && !rst;

  // On a tie, the requester not served last wins.
  assign gnt  = (bus.req0_valid && bus.req1_valid) ?
                ~last_grant : bus.req1_valid;
  assign take = idle && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = idle && bus.req0_valid && !gnt;
  assign bus.req1_ready = idle && bus.req1_valid && gnt;

  assign nw_sel  = gnt ? bus.req1_nwords : bus.req0_nwords;
  assign n_clamp = (nw_sel == '0 || nw_sel > NMAX) ? NMAX : nw_sel;

  assign bus.add_a   = run ? a_q[ki] : '0;
  assign bus.add_b   = run ? b_q[ki] : '0;
  assign bus.add_cin = run && carry;

  assign bus.res_valid = valid_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      cout_q     <= 1'b0;
      id_q       <= 1'b0;
      valid_q    <= 1'b0;
      n_q        <= '0;
      k          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            a_q        <= gnt ? bus.req1_a : bus.req0_a;
            b_q        <= gnt ? bus.req1_b : bus.req0_b;
            carry      <= gnt ? bus.req1_cin : bus.req0_cin;
            n_q        <= n_clamp;
            last_grant <= gnt;
            id_q       <= gnt;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            k          <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[ki] <= bus.add_sum;
          carry     <= bus.add_cout;
          k         <= k + 1'b1;
          if (k == n_q - 1'b1) begin
            cout_q  <= bus.add_cout;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
